// File: rtl/note_envelope_pwm.sv
// Attack/sustain/release envelope with PWM-gated tone output for a speaker pin.
// Optional feature macro ENV_VOLUME_EN adds a vol_shift attenuation input (duty = level >> vol_shift).
module note_envelope_pwm #(
    parameter int PWM_BITS     = 8,
    parameter int STEP_DIV     = 100000,
    parameter int ATTACK_STEP  = 8,
    parameter int SUSTAIN_LVL  = 192,
    parameter int RELEASE_STEP = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tone_in,
    input  logic                key_on,
`ifdef ENV_VOLUME_EN
    input  logic [1:0]          vol_shift,
`endif
    output logic                speaker,
    output logic [PWM_BITS-1:0] level,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ATTACK  = 2'b01,
        SUSTAIN = 2'b10,
        RELEASE = 2'b11
    } env_state_t;

    localparam int TICK_W = $clog2(STEP_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS:0] SUS_W = (PWM_BITS+1)'(SUSTAIN_LVL);
    // Oversized steps are clamped; any clamped step still lands on the same end level.
    localparam logic [PWM_BITS:0] ATK_INC =
        (ATTACK_STEP > SUSTAIN_LVL) ? SUS_W : (PWM_BITS+1)'(ATTACK_STEP);
    localparam logic [PWM_BITS:0] REL_DEC =
        (RELEASE_STEP >= 2**PWM_BITS) ? {1'b0, {PWM_BITS{1'b1}}} : (PWM_BITS+1)'(RELEASE_STEP);

    env_state_t          state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick, tick_clr;
    logic [PWM_BITS-1:0] pwm_cnt, duty;
    logic [PWM_BITS:0]   attack_sum;

    assign tick       = (tick_cnt == TICK_LAST);
    assign attack_sum = {1'b0, level_q} + ATK_INC;

`ifdef ENV_VOLUME_EN
    assign duty = level_q >> vol_shift;
`else
    assign duty = level_q;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        tick_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_on) begin
                    state_d  = ATTACK;
                    tick_clr = 1'b1;
                end
            end
            ATTACK: begin
                if (!key_on) begin
                    state_d = RELEASE;
                end else if (tick) begin
                    if (attack_sum >= SUS_W) begin
                        level_d = SUS_W[PWM_BITS-1:0];
                        state_d = SUSTAIN;
                    end else begin
                        level_d = attack_sum[PWM_BITS-1:0];
                    end
                end
            end
            SUSTAIN: begin
                if (!key_on) state_d = RELEASE;
            end
            RELEASE: begin
                // Retrigger resumes the attack from the current level, not from zero.
                if (key_on) begin
                    state_d = ATTACK;
                end else if (tick) begin
                    if ({1'b0, level_q} <= REL_DEC) begin
                        level_d = '0;
                        state_d = IDLE;
                    end else begin
                        level_d = level_q - REL_DEC[PWM_BITS-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            level_q  <= '0;
            tick_cnt <= '0;
            pwm_cnt  <= '0;
            speaker  <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            tick_cnt <= (tick_clr || tick) ? '0 : tick_cnt + TICK_W'(1);
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            speaker  <= tone_in & (pwm_cnt < duty);
        end
    end

    assign level = level_q;
    assign state = state_q;

endmodule

// File: tb/tb_note_envelope_pwm.sv
// Self-checking bench for note_envelope_pwm: directed envelope scenarios plus randomized
// key/tone/reset stimulus scored cycle by cycle against an integer reference model.
module tb_note_envelope_pwm;

    localparam int PWM_BITS     = 8;
    localparam int STEP_DIV     = 4;
    localparam int ATTACK_STEP  = 64;
    localparam int SUSTAIN_LVL  = 192;
    localparam int RELEASE_STEP = 64;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ATK  = 2'd1;
    localparam logic [1:0] S_SUS  = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic                clk;
    logic                rst_n;
    logic                tone_in;
    logic                key_on;
`ifdef ENV_VOLUME_EN
    logic [1:0]          vol_shift;
`endif
    logic                speaker;
    logic [PWM_BITS-1:0] level;
    logic [1:0]          state;

    int vectors     = 0;
    int miscompares = 0;

    note_envelope_pwm #(
        .PWM_BITS    (PWM_BITS),
        .STEP_DIV    (STEP_DIV),
        .ATTACK_STEP (ATTACK_STEP),
        .SUSTAIN_LVL (SUSTAIN_LVL),
        .RELEASE_STEP(RELEASE_STEP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tone_in  (tone_in),
        .key_on   (key_on),
`ifdef ENV_VOLUME_EN
        .vol_shift(vol_shift),
`endif
        .speaker  (speaker),
        .level    (level),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: envelope in plain integers, phase = cycles into the current step period.
    typedef struct packed {
        logic [1:0] st;
        int         lvl;
        int         phase;
        int         pwm;
        logic       spk;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t c, logic tone, logic key, int vs);
        model_t n;
        logic   step_now;
        n        = c;
        step_now = (c.phase == STEP_DIV - 1);
        n.phase  = step_now ? 0 : c.phase + 1;
        n.pwm    = (c.pwm + 1) % (1 << PWM_BITS);
        n.spk    = tone && (c.pwm < (c.lvl >> vs));
        case (c.st)
            S_IDLE: if (key) begin n.st = S_ATK; n.phase = 0; end
            S_ATK: begin
                if (!key) n.st = S_REL;
                else if (step_now) begin
                    if (c.lvl + ATTACK_STEP >= SUSTAIN_LVL) begin
                        n.lvl = SUSTAIN_LVL;
                        n.st  = S_SUS;
                    end else n.lvl = c.lvl + ATTACK_STEP;
                end
            end
            S_SUS: if (!key) n.st = S_REL;
            default: begin
                if (key) n.st = S_ATK;
                else if (step_now) begin
                    if (c.lvl <= RELEASE_STEP) begin
                        n.lvl = 0;
                        n.st  = S_IDLE;
                    end else n.lvl = c.lvl - RELEASE_STEP;
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
`ifdef ENV_VOLUME_EN
        else m <= model_step(m, tone_in, key_on, int'(vol_shift));
`else
        else m <= model_step(m, tone_in, key_on, 0);
`endif
    end

    task automatic clock_and_score(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vectors++;
            if (speaker !== m.spk || level !== PWM_BITS'(m.lvl) || state !== m.st) begin
                miscompares++;
                $display("FAIL scoreboard @%0t: dut spk=%b lvl=%0d st=%0d, model spk=%b lvl=%0d st=%0d",
                         $time, speaker, level, state, m.spk, m.lvl, m.st);
            end
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        for (int i = 0; i < budget; i++) begin
            clock_and_score(1);
            if (state === s) break;
        end
    endtask

    task automatic wait_level(input int lv, input int budget);
        for (int i = 0; i < budget; i++) begin
            clock_and_score(1);
            if (level === PWM_BITS'(lv)) break;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        key_on  = 1'b0;
        tone_in = 1'b0;
`ifdef ENV_VOLUME_EN
        vol_shift = 2'd0;
`endif
        #1 rst_n = 1'b0;
        #2;
        vectors++;
        if (speaker !== 1'b0 || level !== '0 || state !== S_IDLE) begin
            miscompares++;
            $display("FAIL reset_values: got spk=%b lvl=%0d st=%0d, expected 0/0/0", speaker, level, state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clock_and_score(2);
        vectors++;
        if (state !== S_IDLE || level !== '0) begin
            miscompares++;
            $display("FAIL idle_hold: got lvl=%0d st=%0d, expected 0/0", level, state);
        end
    endtask

    task automatic test_attack();
        int exp_lvl;
        logic [1:0] exp_st;
        key_on  = 1'b1;
        tone_in = 1'b1;
        clock_and_score(1);
        vectors++;
        if (state !== S_ATK || level !== '0) begin
            miscompares++;
            $display("FAIL attack_entry: got lvl=%0d st=%0d, expected 0/1", level, state);
        end
        for (int k = 1; k <= 3 * STEP_DIV; k++) begin
            clock_and_score(1);
            if (k == STEP_DIV - 1 || k % STEP_DIV == 0) begin
                exp_lvl = (k / STEP_DIV) * ATTACK_STEP;
                if (exp_lvl > SUSTAIN_LVL) exp_lvl = SUSTAIN_LVL;
                exp_st = (exp_lvl >= SUSTAIN_LVL) ? S_SUS : S_ATK;
                vectors++;
                if (level !== PWM_BITS'(exp_lvl) || state !== exp_st) begin
                    miscompares++;
                    $display("FAIL attack_cycle_%0d: got lvl=%0d st=%0d, expected %0d/%0d",
                             k, level, state, exp_lvl, exp_st);
                end
            end
        end
    endtask

    task automatic test_sustain_pwm();
        int highs = 0;
        for (int i = 0; i < (1 << PWM_BITS); i++) begin
            clock_and_score(1);
            if (speaker === 1'b1) highs++;
        end
        vectors++;
        if (highs != SUSTAIN_LVL || state !== S_SUS) begin
            miscompares++;
            $display("FAIL sustain_duty: got %0d highs st=%0d, expected %0d highs st=2",
                     highs, state, SUSTAIN_LVL);
        end
    endtask

    task automatic test_release();
        key_on = 1'b0;
        clock_and_score(1);
        vectors++;
        if (state !== S_REL || level !== PWM_BITS'(SUSTAIN_LVL)) begin
            miscompares++;
            $display("FAIL release_entry: got lvl=%0d st=%0d, expected %0d/3", level, state, SUSTAIN_LVL);
        end
        for (int e = SUSTAIN_LVL - RELEASE_STEP; e >= 0; e -= RELEASE_STEP) begin
            wait_level(e, STEP_DIV);
            vectors++;
            if (level !== PWM_BITS'(e) || state !== ((e == 0) ? S_IDLE : S_REL)) begin
                miscompares++;
                $display("FAIL release_step_%0d: got lvl=%0d st=%0d", e, level, state);
            end
        end
    endtask

    task automatic test_retrigger();
        key_on = 1'b1;
        wait_state(S_SUS, 30);
        key_on = 1'b0;
        wait_level(64, 20);
        vectors++;
        if (level !== 8'd64 || state !== S_REL) begin
            miscompares++;
            $display("FAIL retrig_setup: got lvl=%0d st=%0d, expected 64/3", level, state);
        end
        key_on = 1'b1;
        clock_and_score(1);
        vectors++;
        if (state !== S_ATK || level !== 8'd64) begin
            miscompares++;
            $display("FAIL retrig_entry: got lvl=%0d st=%0d, expected 64/1", level, state);
        end
        wait_level(128, STEP_DIV);
        vectors++;
        if (level !== 8'd128 || state !== S_ATK) begin
            miscompares++;
            $display("FAIL retrig_step: got lvl=%0d st=%0d, expected 128/1", level, state);
        end
        for (int i = 0; i < STEP_DIV; i++) begin
            if (m.phase == STEP_DIV - 1) break;
            clock_and_score(1);
        end
        key_on = 1'b0;
        clock_and_score(1);
        vectors++;
        if (state !== S_REL || level !== 8'd128) begin
            miscompares++;
            $display("FAIL release_beats_tick: got lvl=%0d st=%0d, expected 128/3", level, state);
        end
        wait_state(S_IDLE, 20);
    endtask

    task automatic test_tone_gate();
        int highs = 0;
        key_on  = 1'b1;
        tone_in = 1'b0;
        wait_state(S_SUS, 30);
        for (int i = 0; i < (1 << PWM_BITS); i++) begin
            clock_and_score(1);
            if (speaker === 1'b1) highs++;
        end
        vectors++;
        if (highs != 0 || level !== PWM_BITS'(SUSTAIN_LVL)) begin
            miscompares++;
            $display("FAIL tone_gate: got %0d highs lvl=%0d, expected 0 highs lvl=%0d", highs, level, SUSTAIN_LVL);
        end
`ifdef ENV_VOLUME_EN
        highs     = 0;
        vol_shift = 2'd2;
        tone_in   = 1'b1;
        for (int i = 0; i < (1 << PWM_BITS); i++) begin
            clock_and_score(1);
            if (speaker === 1'b1) highs++;
        end
        vectors++;
        if (highs != (SUSTAIN_LVL >> 2)) begin
            miscompares++;
            $display("FAIL vol_shift2_duty: got %0d highs, expected %0d", highs, SUSTAIN_LVL >> 2);
        end
        vol_shift = 2'd0;
`endif
    endtask

    task automatic test_async_reset();
        key_on = 1'b0;
        wait_state(S_IDLE, 30);
        key_on  = 1'b1;
        tone_in = 1'b1;
        wait_level(128, 20);
        vectors++;
        if (level !== 8'd128 || state !== S_ATK) begin
            miscompares++;
            $display("FAIL areset_setup: got lvl=%0d st=%0d, expected 128/1", level, state);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (speaker !== 1'b0 || level !== '0 || state !== S_IDLE) begin
            miscompares++;
            $display("FAIL areset_no_edge: got spk=%b lvl=%0d st=%0d, expected 0/0/0", speaker, level, state);
        end
        key_on = 1'b0;
        #3 rst_n = 1'b1;
        clock_and_score(2);
    endtask

    task automatic test_random();
        key_on  = 1'b0;
        tone_in = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) key_on = ~key_on;
            tone_in = ($urandom_range(3) != 0);
`ifdef ENV_VOLUME_EN
            if ($urandom_range(63) == 0) vol_shift = 2'($urandom_range(3));
`endif
            if ($urandom_range(499) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                vectors++;
                if (speaker !== 1'b0 || level !== '0 || state !== S_IDLE) begin
                    miscompares++;
                    $display("FAIL random_reset: got spk=%b lvl=%0d st=%0d", speaker, level, state);
                end
                #3 rst_n = 1'b1;
            end
            clock_and_score(1);
            vectors++;
            if (level > SUSTAIN_LVL) begin
                miscompares++;
                $display("FAIL level_bound: got %0d, limit %0d", level, SUSTAIN_LVL);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_attack();
        test_sustain_pwm();
        test_release();
        test_retrigger();
        test_tone_gate();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
